// File: rtl/uart_prog_loader.sv
// UART program loader: receives a length-prefixed little-endian image over 8N1 serial
// and writes it word by word into instruction memory, holding the CPU in reset meanwhile.
module uart_prog_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              uart_rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [31:0]      MAX_WORDS = 32'd1 << ADDR_W;
  localparam logic [ADDR_W:0]  CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_IDLE, L_LEN0, L_LEN1, L_DATA} ld_state_t;

  // Input synchronizer
  logic rx_meta_reg, rx_sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= uart_rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // Byte receiver
  rx_state_t        rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]       rx_bit_reg, rx_bit_next;
  logic [7:0]       rx_shift_reg, rx_shift_next;
  logic             byte_valid_reg, byte_valid_next;
  logic             frame_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_reg   <= R_IDLE;
      rx_cnt_reg     <= '0;
      rx_bit_reg     <= '0;
      rx_shift_reg   <= '0;
      byte_valid_reg <= 1'b0;
    end else begin
      rx_state_reg   <= rx_state_next;
      rx_cnt_reg     <= rx_cnt_next;
      rx_bit_reg     <= rx_bit_next;
      rx_shift_reg   <= rx_shift_next;
      byte_valid_reg <= byte_valid_next;
    end
  end

  always_comb begin
    rx_state_next   = rx_state_reg;
    rx_cnt_next     = rx_cnt_reg;
    rx_bit_next     = rx_bit_reg;
    rx_shift_next   = rx_shift_reg;
    byte_valid_next = 1'b0;
    frame_err       = 1'b0;
    case (rx_state_reg)
      R_IDLE: begin
        rx_cnt_next = '0;
        if (!rx_sync_reg) rx_state_next = R_START;
      end
      R_START: begin
        // Mid-start-bit resample rejects short glitches on the line
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_sync_reg ? R_IDLE : R_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_W'(1);
        end
      end
      R_DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          rx_bit_next   = rx_bit_reg + 3'd1;
          if (rx_bit_reg == 3'd7) rx_state_next = R_STOP;
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_W'(1);
        end
      end
      R_STOP: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next     = '0;
          byte_valid_next = rx_sync_reg;
          frame_err       = !rx_sync_reg;
          rx_state_next   = R_IDLE;
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_W'(1);
        end
      end
      default: rx_state_next = R_IDLE;
    endcase
  end

  // Loader
  ld_state_t         ld_state_reg, ld_state_next;
  logic [15:0]       len_reg, len_next;
  logic [ADDR_W:0]   word_cnt_reg, word_cnt_next;
  logic [1:0]        byte_idx_reg, byte_idx_next;
  logic [31:0]       word_reg, word_asm;
  logic              lane_we;
  logic              err_reg, err_next;
  logic              done_reg, done_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [31:0]       mem_wdata_reg, mem_wdata_next;
  logic              cpu_rst_n_reg, cpu_rst_n_next;
  logic [15:0]       len_full;

  assign len_full = {rx_shift_reg, len_reg[7:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign word_asm[8*gi +: 8] = (lane_we && (byte_idx_reg == 2'(gi))) ?
                                   rx_shift_reg : word_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    ld_state_next  = ld_state_reg;
    len_next       = len_reg;
    word_cnt_next  = word_cnt_reg;
    byte_idx_next  = byte_idx_reg;
    err_next       = err_reg;
    done_next      = 1'b0;
    mem_we_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    lane_we        = 1'b0;
    case (ld_state_reg)
      L_IDLE: begin
        if (load_en) begin
          err_next      = 1'b0;
          word_cnt_next = '0;
          byte_idx_next = '0;
          ld_state_next = L_LEN0;
        end
      end
      L_LEN0: begin
        if (frame_err) begin
          err_next      = 1'b1;
          ld_state_next = L_IDLE;
        end else if (byte_valid_reg) begin
          len_next[7:0] = rx_shift_reg;
          ld_state_next = L_LEN1;
        end
      end
      L_LEN1: begin
        if (frame_err) begin
          err_next      = 1'b1;
          ld_state_next = L_IDLE;
        end else if (byte_valid_reg) begin
          len_next = len_full;
          if (len_full == 16'd0) begin
            done_next     = 1'b1;
            ld_state_next = L_IDLE;
          end else if ({16'd0, len_full} > MAX_WORDS) begin
            err_next      = 1'b1;
            ld_state_next = L_IDLE;
          end else begin
            ld_state_next = L_DATA;
          end
        end
      end
      L_DATA: begin
        if (frame_err) begin
          err_next      = 1'b1;
          ld_state_next = L_IDLE;
        end else if (byte_valid_reg) begin
          lane_we       = 1'b1;
          byte_idx_next = byte_idx_reg + 2'd1;
          if (byte_idx_reg == 2'd3) begin
            mem_we_next    = 1'b1;
            mem_addr_next  = word_cnt_reg[ADDR_W-1:0];
            mem_wdata_next = word_asm;
            word_cnt_next  = word_cnt_reg + CNT_ONE;
          end
        end else if (32'(word_cnt_reg) == 32'(len_reg)) begin
          // Checked the cycle after the final write so done trails mem_we by one
          done_next     = 1'b1;
          ld_state_next = L_IDLE;
        end
      end
      default: ld_state_next = L_IDLE;
    endcase
  end

  // Held low across both the leaving and the entering cycle of any active state
  assign cpu_rst_n_next = !((ld_state_reg != L_IDLE) || (ld_state_next != L_IDLE) ||
                            err_reg || err_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      ld_state_reg  <= L_IDLE;
      len_reg       <= '0;
      word_cnt_reg  <= '0;
      byte_idx_reg  <= '0;
      word_reg      <= '0;
      err_reg       <= 1'b0;
      done_reg      <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      cpu_rst_n_reg <= 1'b0;
    end else begin
      ld_state_reg  <= ld_state_next;
      len_reg       <= len_next;
      word_cnt_reg  <= word_cnt_next;
      byte_idx_reg  <= byte_idx_next;
      word_reg      <= word_asm;
      err_reg       <= err_next;
      done_reg      <= done_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      cpu_rst_n_reg <= cpu_rst_n_next;
    end
  end

  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign cpu_rst_n = cpu_rst_n_reg;
  assign busy      = (ld_state_reg != L_IDLE);
  assign done      = done_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: serial image loads (fixed and random) compared against
// an image-level reference model of the expected writes, done and err outcome.
module tb_uart_prog_loader;

  localparam int CPB = 4;
  localparam int AW  = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          load_en = 1'b0;
  logic          uart_rx = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst_n, busy, done, err;

  uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .uart_rx(uart_rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Observed activity, collected on the falling edge
  int          obs_addr[$];
  logic [31:0] obs_data[$];
  int          cyc = 0, last_we_cyc = -10, done_cyc = -10, done_cnt = 0;
  logic        prev_we = 1'b0, prev_done = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (mem_we === 1'b1) begin
      check("we_gap", 32'(prev_we), 32'd0);
      obs_addr.push_back(int'(mem_addr));
      obs_data.push_back(mem_wdata);
      last_we_cyc = cyc;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_busy", 32'(busy), 32'd0);
      check("done_rstn", 32'(cpu_rst_n), 32'd0);
    end
    if (prev_done === 1'b1) check("rstn_after_done", 32'(cpu_rst_n), 32'd1);
    if (busy === 1'b1) check("rstn_busy", 32'(cpu_rst_n), 32'd0);
    prev_we   = mem_we;
    prev_done = done;
  end

  // Reference model: outcome of a load computed from the byte image alone
  logic [7:0]  tx_q[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];
  bit          exp_done, exp_err;

  task automatic build_expected(input int bad);
    int n;
    exp_addr.delete();
    exp_data.delete();
    exp_done = 0;
    exp_err  = 0;
    if (bad == 0 || bad == 1) begin exp_err = 1; return; end
    n = int'(tx_q[0]) + 256 * int'(tx_q[1]);
    if (n == 0) begin exp_done = 1; return; end
    if (n > (1 << AW)) begin exp_err = 1; return; end
    for (int i = 0; i < n; i++) begin
      int b;
      b = 2 + 4 * i;
      if (bad >= 0 && bad < b + 4) begin exp_err = 1; return; end
      exp_addr.push_back(i);
      exp_data.push_back({tx_q[b+3], tx_q[b+2], tx_q[b+1], tx_q[b]});
    end
    exp_done = 1;
  endtask

  // Called on a falling edge; returns on a falling edge
  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      uart_rx = b[k];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    repeat ($urandom_range(2, 6)) @(negedge clk);
  endtask

  task automatic run_load(input int bad, input bit glitch, input bit poke_en);
    int t;
    int m;
    build_expected(bad);
    obs_addr.delete();
    obs_data.delete();
    done_cnt = 0;
    last_we_cyc = -10;
    done_cyc = -10;
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_rstn", 32'(cpu_rst_n), 32'd0);
    if (glitch) begin
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (20) @(negedge clk);
    end
    for (int i = 0; i < tx_q.size(); i++) begin
      send_byte(tx_q[i], i != bad);
      if (poke_en && i == 2) begin
        load_en = 1'b1;
        repeat (2) @(negedge clk);
        load_en = 1'b0;
      end
    end
    t = 0;
    while (busy !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    check("n_writes", 32'(obs_addr.size()), 32'(exp_addr.size()));
    m = (obs_addr.size() < exp_addr.size()) ? obs_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      check("waddr", 32'(obs_addr[i]), 32'(exp_addr[i]));
      check("wdata", obs_data[i], exp_data[i]);
    end
    check("done_cnt", 32'(done_cnt), 32'(exp_done));
    if (exp_done && exp_addr.size() > 0) check("done_lat", 32'(done_cyc - last_we_cyc), 32'd1);
    check("err", 32'(err), 32'(exp_err));
    check("rstn_post", 32'(cpu_rst_n), 32'(!exp_err));
    $display("load: bytes=%0d bad=%0d glitch=%0d writes=%0d done=%0d err=%0d",
             tx_q.size(), bad, glitch, obs_addr.size(), done_cnt, err);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    32'(mem_we), 32'd0);
    check({tag, "_addr"},  32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_rstn"},  32'(cpu_rst_n), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
  endtask

  initial begin
    logic [31:0] w;
    int n, bad;
    bit poke;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check("release_rstn", 32'(cpu_rst_n), 32'd1);

    // Two-word load
    tx_q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load(-1, 1'b0, 1'b0);
    w = (obs_data.size() > 1) ? obs_data[1] : 32'h0;
    check("two_word_w1", w, 32'hDEADBEEF);

    // Empty image
    tx_q = '{8'h00, 8'h00};
    run_load(-1, 1'b0, 1'b0);

    // Framing error on the fourth byte, then a good load
    tx_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_load(3, 1'b0, 1'b0);
    tx_q = '{8'h01, 8'h00, 8'hA5, 8'h5A, 8'hC3, 8'h3C};
    run_load(-1, 1'b0, 1'b0);

    // Glitch rejection
    tx_q = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    run_load(-1, 1'b1, 1'b0);
    w = (obs_data.size() > 0) ? obs_data[0] : 32'h0;
    check("glitch_word", w, 32'h44332211);

    // Reset mid-load after three data bytes
    obs_addr.delete();
    obs_data.delete();
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    tx_q = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    for (int i = 0; i < tx_q.size(); i++) send_byte(tx_q[i], 1'b1);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("midrst");
    check("midrst_nowrite", 32'(obs_addr.size()), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_release", 32'(cpu_rst_n), 32'd1);
    tx_q = '{8'h01, 8'h00, 8'hDE, 8'hC0, 8'hAD, 8'h0B};
    run_load(-1, 1'b0, 1'b0);

    // Oversize length
    tx_q = '{8'h01, 8'h40};
    run_load(-1, 1'b0, 1'b0);

    // Random loads, some with a corrupted stop bit, some with load_en re-asserted mid-load
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 4);
      tx_q.delete();
      tx_q.push_back(8'(n));
      tx_q.push_back(8'h00);
      for (int i = 0; i < 4 * n; i++) tx_q.push_back(8'($urandom));
      bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1 + 4 * n)) : -1;
      poke = (bad < 0 || bad > 2) && ($urandom_range(0, 1) == 1);
      run_load(bad, 1'b0, poke);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
